splitter: RTL

- Inverse of the list reduction adder: takes one scalar total and distributes it as evenly as possible across a LENGTH-element packed vector.
- The sum of the output elements always equals the accepted total, unless overflow is flagged.
- Sits downstream of list/adder logic, e.g. to spread an aggregate budget or credit back over list slots.
- Sequential: a restoring divider computes the quotient and remainder; the element vector is then produced from them.

---
 rtl/list_pkg.sv | 16 +
 rtl/seq_divider.sv | 94 +++++++++
 rtl/splitter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/list_pkg.sv
// Shared types and helpers for the list datapath blocks (adder/splitter family).
package list_pkg;

  // Splitter control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } split_state_e;

  // $clog2 that never returns 0, so a width derived from it is always usable.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: IN_WIDTH-bit dividend by a constant divisor, one
// quotient bit per cycle, MSB first. The quotient is built in place in the
// dividend shift register. done pulses for one cycle after the last step.
module seq_divider
  import list_pkg::*;
#(
  parameter  int IN_WIDTH  = 35,
  parameter  int DIVISOR   = 8,
  // DIVISOR must not exceed 2**REM_WIDTH.
  parameter  int REM_WIDTH = 3,
  localparam int CNT_WIDTH = clog2_min1(IN_WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [IN_WIDTH-1:0] dividend,
  output logic                busy,
  output logic                done,
  output logic [IN_WIDTH-1:0] quotient,
  // One extra bit holds the trial-subtract sign; it is always 0 here.
  output logic [REM_WIDTH:0]  remainder
);

  localparam logic [REM_WIDTH:0] DIVISOR_C = (REM_WIDTH + 1)'(DIVISOR);

  logic [IN_WIDTH-1:0]  quo_q, quo_d;
  logic [REM_WIDTH:0]   rem_q, rem_d;
  logic [REM_WIDTH:0]   rem_shift, trial;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next-state: load on start, otherwise one shift/trial-subtract per cycle.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rem_shift = {rem_q[REM_WIDTH-1:0], quo_q[IN_WIDTH-1]};
    trial     = rem_shift - DIVISOR_C;

    if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (abort) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      // Sign bit set means the trial went negative: restore and shift in 0.
      if (trial[REM_WIDTH]) begin
        rem_d = rem_shift;
        quo_d = {quo_q[IN_WIDTH-2:0], 1'b0};
      end else begin
        rem_d = trial;
        quo_d = {quo_q[IN_WIDTH-2:0], 1'b1};
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_WIDTH'(IN_WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input from before the edge, independent of statement order.
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/splitter.sv
// Distributes a scalar total as evenly as possible over LENGTH elements:
// element i gets q+1 for i < r, else q, where q/r = total divided by LENGTH.
// Totals above LENGTH*(2^DATA_WIDTH-1) are flagged and produce all zeros.
module splitter
  import list_pkg::*;
#(
  parameter  int DATA_WIDTH   = 32,
  parameter  int LENGTH       = 8,
  localparam int LENGTH_WIDTH = clog2_min1(LENGTH),
  localparam int IN_WIDTH     = LENGTH_WIDTH + DATA_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [IN_WIDTH-1:0]                total_in,
  input  logic                               split_en,
  output logic [LENGTH-1:0][DATA_WIDTH-1:0]  data_out,
  output logic                               split_done,
  output logic                               split_in_progress,
  output logic                               split_ovf
);

  // Largest representable total, evaluated one bit wider than the input.
  localparam logic [IN_WIDTH:0] ELEM_MAX  =
    {{(IN_WIDTH + 1 - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
  localparam logic [IN_WIDTH:0] TOTAL_MAX = ELEM_MAX * (IN_WIDTH + 1)'(LENGTH);

  split_state_e                     state_q, state_d;
  logic [IN_WIDTH-1:0]              total_q, total_d;
  logic [LENGTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic                             done_q, done_d;
  logic                             ovf_q, ovf_d;

  logic                             div_start, div_abort;
  logic                             div_busy, div_done;
  logic [IN_WIDTH-1:0]              div_quo;
  logic [LENGTH_WIDTH:0]            div_rem;

  logic [DATA_WIDTH-1:0]            quo_sat;
  logic                             total_ovf;
  logic [LENGTH-1:0][DATA_WIDTH-1:0] expand;

  seq_divider #(
    .IN_WIDTH  (IN_WIDTH),
    .DIVISOR   (LENGTH),
    .REM_WIDTH (LENGTH_WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .abort     (div_abort),
    .dividend  (total_in),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Overflow check and element expansion from the divider result.
  always_comb begin
    // High quotient bits are only nonzero on overflow, where the elements
    // are zeroed anyway; saturating keeps the element path well defined.
    quo_sat   = (|div_quo[IN_WIDTH-1:DATA_WIDTH]) ? '1 : div_quo[DATA_WIDTH-1:0];
    total_ovf = {1'b0, total_q} > TOTAL_MAX;
    for (int i = 0; i < LENGTH; i++) begin
      expand[i] = ((LENGTH_WIDTH + 1)'(i) < div_rem) ? quo_sat + 1'b1 : quo_sat;
    end
  end

  // Control FSM: accept, wait for the divider, hold the result until released.
  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    data_d    = data_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    div_start = 1'b0;
    div_abort = 1'b0;

    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        ovf_d  = 1'b0;
        if (split_en) begin
          total_d   = total_in;
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: begin
        if (!split_en) begin
          div_abort = 1'b1;
          state_d   = IDLE;
        end else if (div_done) begin
          done_d  = 1'b1;
          ovf_d   = total_ovf;
          data_d  = total_ovf ? '0 : expand;
          state_d = DONE;
        end
      end
      DONE: begin
        // Staying high here never restarts; a low cycle is needed to re-arm.
        if (!split_en) begin
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      total_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out          = data_q;
  assign split_done        = done_q;
  assign split_in_progress = div_busy;
  assign split_ovf         = ovf_q;

endmodule
